// File: rtl/ofdm_cp_stripper.sv
// Strips burst guard and cyclic-prefix samples from a continuous baseband stream and
// emits each OFDM symbol body as an FFT_LEN-sample AXIS packet with tlast on its last sample.
module ofdm_cp_stripper #(
   parameter int unsigned FFT_LEN     = 64,
   parameter int unsigned FIRST_GI    = 32,
   parameter int unsigned CP_LEN      = 16,
   parameter int unsigned NUM_SYMBOLS = 2
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        sample_axis_tvalid,
   input  logic [15:0] sample_re_axis_tdata,
   input  logic [15:0] sample_im_axis_tdata,
   output logic        sample_axis_tready,
   input  logic        start_in,
   output logic        out_axis_tvalid,
   output logic        out_axis_tlast,
   output logic [15:0] out_re_axis_tdata,
   output logic [15:0] out_im_axis_tdata,
   input  logic        out_axis_tready,
   output logic        busy_out,
   output logic        start_dropped_out
);

   // Counter must also reach CP_LEN-1 when guards longer than the body are configured.
   localparam int unsigned MaxLenA = (FFT_LEN > FIRST_GI) ? FFT_LEN : FIRST_GI;
   localparam int unsigned MaxLen  = (MaxLenA > CP_LEN) ? MaxLenA : CP_LEN;
   localparam int unsigned CntW    = (MaxLen > 1) ? $clog2(MaxLen) : 1;
   localparam int unsigned SymW    = $clog2(NUM_SYMBOLS + 1);

   typedef enum logic [1:0] {StIdle, StSkip, StPass} state_e;

   state_e            state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [SymW-1:0]   sym_q, sym_d;
   logic              first_q, first_d;
   logic              out_valid_q, out_last_q, drop_q;
   logic [15:0]       out_re_q, out_im_q;

   logic              in_ready, accept, load, last_beat;
   int unsigned       skip_target;

   always_comb begin
      in_ready    = (state_q == StPass) ? (!out_valid_q || out_axis_tready) : 1'b1;
      accept      = sample_axis_tvalid && in_ready;
      load        = accept && (state_q == StPass);
      last_beat   = load && (32'(cnt_q) == FFT_LEN - 1);
      skip_target = first_q ? FIRST_GI : CP_LEN;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sym_d   = sym_q;
      first_d = first_q;
      unique case (state_q)
         StIdle: begin
            // The start beat itself is the first guard sample.
            if (accept && start_in) begin
               first_d = 1'b1;
               sym_d   = '0;
               if (FIRST_GI == 1) begin
                  state_d = StPass;
                  cnt_d   = '0;
               end else begin
                  state_d = StSkip;
                  cnt_d   = CntW'(1);
               end
            end
         end
         StSkip: begin
            if (accept) begin
               if (32'(cnt_q) + 1 == skip_target) begin
                  state_d = StPass;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CntW'(1);
               end
            end
         end
         StPass: begin
            if (accept) begin
               if (last_beat) begin
                  sym_d = sym_q + SymW'(1);
                  cnt_d = '0;
                  if (32'(sym_q) + 1 == NUM_SYMBOLS) begin
                     state_d = StIdle;
                  end else begin
                     state_d = StSkip;
                     first_d = 1'b0;
                  end
               end else begin
                  cnt_d = cnt_q + CntW'(1);
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         sym_q   <= '0;
         first_q <= 1'b0;
         drop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sym_q   <= sym_d;
         first_q <= first_d;
         drop_q  <= accept && start_in && (state_q != StIdle);
      end
   end

   // Output register: loaded only in PASS, otherwise drains on downstream ready.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_re_q    <= '0;
         out_im_q    <= '0;
      end else if (load) begin
         out_valid_q <= 1'b1;
         out_last_q  <= last_beat;
         out_re_q    <= sample_re_axis_tdata;
         out_im_q    <= sample_im_axis_tdata;
      end else if (out_axis_tready) begin
         out_valid_q <= 1'b0;
      end
   end

   assign sample_axis_tready = in_ready;
   assign out_axis_tvalid    = out_valid_q;
   assign out_axis_tlast     = out_last_q;
   assign out_re_axis_tdata  = out_re_q;
   assign out_im_axis_tdata  = out_im_q;
   assign busy_out           = (state_q != StIdle);
   assign start_dropped_out  = drop_q;

endmodule
